mod_sync_timer: RTL

- Consumes the modulation sync bundle (init flag, cycle, divider, sync time) from the configuration stage.
- Produces the running modulation sample index used to address modulation BRAM.
- Aligns index 0 to an absolute system time in ns, so all devices on the bus start modulation on the same tick.
- Sits between the config stage and the modulation sampler.

---
 rtl/mod_sync_pkg.sv | 13 +
 rtl/mod_sync_timer_if.sv | 26 ++
 rtl/mod_tick_divider.sv | 35 +++
 rtl/mod_sync_timer.sv | 117 +++++++++++
 4 files changed

// File: rtl/mod_sync_pkg.sv
// Shared constants and state encoding for the modulation sync timer slice.
package mod_sync_pkg;

  localparam int TIME_W = 64;
  localparam int IDX_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } sync_state_t;

endpackage

// File: rtl/mod_sync_timer_if.sv
// Modulation sync bundle from the configuration stage to the sync timer.
interface mod_sync_timer_if #(
  parameter int TIME_W = mod_sync_pkg::TIME_W,
  parameter int IDX_W  = mod_sync_pkg::IDX_W
);

  logic              MOD_CLK_INIT;
  logic [IDX_W-1:0]  MOD_CLK_CYCLE;
  logic [IDX_W-1:0]  MOD_CLK_DIV;
  logic [TIME_W-1:0] MOD_CLK_SYNC_TIME_NS;

  modport master (
    output MOD_CLK_INIT,
    output MOD_CLK_CYCLE,
    output MOD_CLK_DIV,
    output MOD_CLK_SYNC_TIME_NS
  );

  modport slave (
    input MOD_CLK_INIT,
    input MOD_CLK_CYCLE,
    input MOD_CLK_DIV,
    input MOD_CLK_SYNC_TIME_NS
  );

endinterface

// File: rtl/mod_tick_divider.sv
// Divides the base TICK by a live divider value; emits a step strobe on the
// TICK that completes each division period.
module mod_tick_divider
  import mod_sync_pkg::*;
#(
  parameter int DIV_W = IDX_W
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             tick,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             step
);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_max;

  // A divider of 0 behaves like 1; >= lets a shrunk divider wrap immediately.
  assign div_max = (div == '0) ? '0 : div - DIV_W'(1);
  assign step    = tick && (div_cnt >= div_max);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt <= '0;
    end else if (clear) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= step ? '0 : div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/mod_sync_timer.sv
// Modulation sync timer: aligns modulation index 0 to an absolute system time
// and steps the index on divided TICKs. Optional late-arm flag: MOD_SYNC_LATE_DETECT_EN.
module mod_sync_timer
  import mod_sync_pkg::*;
#(
  parameter int TIME_W = mod_sync_pkg::TIME_W,
  parameter int IDX_W  = mod_sync_pkg::IDX_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [TIME_W-1:0] SYS_TIME,
  input  logic              TICK,
  mod_sync_timer_if.slave   cfg,
  output logic [IDX_W-1:0]  MOD_IDX,
  output logic              IDX_UPDATE,
  output logic              SYNC_PULSE,
  output logic              SYNCED,
  output logic              SYNC_LATE
);

  sync_state_t       state_q;
  sync_state_t       state_d;
  logic              init_q;
  logic              init_rise;
  logic [TIME_W-1:0] sync_t;
  logic              sync_hit;
  logic              align;
  logic              tick_run;
  logic              step;
  logic [IDX_W-1:0]  mod_idx_d;
  logic              idx_update_d;
  logic              sync_pulse_d;

  assign init_rise = cfg.MOD_CLK_INIT & ~init_q;
  assign sync_hit  = (SYS_TIME >= sync_t);
  assign align     = (state_q == ARMED) && (state_d == RUN);
  // A re-arm request takes priority over a coincident TICK.
  assign tick_run  = TICK && (state_q == RUN) && !init_rise;
  assign SYNCED    = (state_q == RUN);

  mod_tick_divider #(
    .DIV_W (IDX_W)
  ) u_divider (
    .CLK   (CLK),
    .RST_N (RST_N),
    .tick  (tick_run),
    .clear (align),
    .div   (cfg.MOD_CLK_DIV),
    .step  (step)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (init_rise) state_d = ARMED;
      ARMED:   if (init_rise) state_d = ARMED;
               else if (sync_hit) state_d = RUN;
      RUN:     if (init_rise) state_d = ARMED;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    mod_idx_d    = MOD_IDX;
    idx_update_d = 1'b0;
    sync_pulse_d = 1'b0;
    if (align) begin
      mod_idx_d    = '0;
      idx_update_d = 1'b1;
      sync_pulse_d = 1'b1;
    end else if (step) begin
      mod_idx_d    = (MOD_IDX >= cfg.MOD_CLK_CYCLE) ? '0 : MOD_IDX + IDX_W'(1);
      idx_update_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      init_q     <= 1'b0;
      sync_t     <= '0;
      MOD_IDX    <= '0;
      IDX_UPDATE <= 1'b0;
      SYNC_PULSE <= 1'b0;
    end else begin
      init_q     <= cfg.MOD_CLK_INIT;
      MOD_IDX    <= mod_idx_d;
      IDX_UPDATE <= idx_update_d;
      SYNC_PULSE <= sync_pulse_d;
      if (init_rise) begin
        sync_t <= cfg.MOD_CLK_SYNC_TIME_NS;
      end
    end
  end

`ifdef MOD_SYNC_LATE_DETECT_EN
  // Each arm either sets or clears the flag, so an on-time re-arm clears it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      SYNC_LATE <= 1'b0;
    end else if (init_rise) begin
      SYNC_LATE <= (SYS_TIME > cfg.MOD_CLK_SYNC_TIME_NS);
    end
  end
`else
  assign SYNC_LATE = 1'b0;
`endif

endmodule
